// File: rtl/sys_arr.sv
// sys_arr: output-stationary ROWS x COLS signed systolic MAC array with internal operand skew.
// Optional macro SYSARR_SAT_EN: saturating accumulate with sticky sat_flag (otherwise wrap, sat_flag tied 0).
//
// state | meaning
// IDLE  | waiting for start; accumulators hold the last tile
// LOAD  | accepting operand beats, bubbles injected on idle cycles
// FLUSH | ROWS+COLS-1 cycles letting the last wavefront reach the far PE
// DRAIN | presenting result rows 0..ROWS-1 with valid/ready handshake
module sys_arr #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int ACCW = 32,
    parameter int KMAX = 255,
    localparam int KW  = $clog2(KMAX + 1),
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*DW-1:0]   in_a,
    input  logic [COLS*DW-1:0]   in_w,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RW-1:0]        out_row,
    output logic [COLS*ACCW-1:0] out_r,
    output logic                 busy,
    output logic                 sat_flag
);

    localparam int FW = $clog2(ROWS + COLS);
    localparam int PW = 2 * DW;
`ifdef SYSARR_SAT_EN
    localparam int SW = ACCW + 1;
`else
    localparam int SW = ACCW;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t state;
    state_t state_nxt;

    logic [KW-1:0] k_reg;
    logic [KW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic          accept;
    logic          out_fire;
    logic          tile_start;
    logic          last_beat;
    logic          last_row;

    logic signed [DW-1:0]   a_dl    [ROWS][ROWS];
    logic signed [DW-1:0]   w_dl    [COLS][COLS];
    logic signed [DW-1:0]   a_pipe  [ROWS][COLS];
    logic signed [DW-1:0]   w_pipe  [ROWS][COLS];
    logic signed [DW-1:0]   a_in    [ROWS][COLS];
    logic signed [DW-1:0]   w_in    [ROWS][COLS];
    logic signed [DW-1:0]   beat_a  [ROWS];
    logic signed [DW-1:0]   beat_w  [COLS];
    logic signed [ACCW-1:0] acc     [ROWS][COLS];
    logic signed [ACCW-1:0] acc_nxt [ROWS][COLS];
    logic signed [PW-1:0]   prod;
    logic signed [SW-1:0]   sum;
`ifdef SYSARR_SAT_EN
    logic                   ovf_any;
`endif

    assign accept     = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign tile_start = (state == IDLE) & start;
    assign last_beat  = accept & ((beat_cnt + KW'(1)) == k_reg);
    assign last_row   = (out_row == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (last_beat) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && last_row) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == DRAIN);
        busy      = (state != IDLE);
    end

    // Non-accepted cycles feed zeros, so the array keeps moving and bubbles add nothing.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            beat_a[i] = accept ? in_a[i*DW +: DW] : '0;
        end
        for (int j = 0; j < COLS; j++) begin
            beat_w[j] = accept ? in_w[j*DW +: DW] : '0;
        end
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                if (j == 0) begin
                    a_in[i][j] = (i == 0) ? beat_a[i] : a_dl[i][(i > 0) ? i - 1 : 0];
                end else begin
                    a_in[i][j] = a_pipe[i][(j > 0) ? j - 1 : 0];
                end
                if (i == 0) begin
                    w_in[i][j] = (j == 0) ? beat_w[j] : w_dl[j][(j > 0) ? j - 1 : 0];
                end else begin
                    w_in[i][j] = w_pipe[(i > 0) ? i - 1 : 0][j];
                end
            end
        end
    end

    always_comb begin
        prod = '0;
        sum  = '0;
`ifdef SYSARR_SAT_EN
        ovf_any = 1'b0;
`endif
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                prod = PW'(a_in[i][j]) * PW'(w_in[i][j]);
                sum  = SW'(acc[i][j]) + SW'(prod);
`ifdef SYSARR_SAT_EN
                if (sum[ACCW] != sum[ACCW-1]) begin
                    acc_nxt[i][j] = sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
                    ovf_any = 1'b1;
                end else begin
                    acc_nxt[i][j] = sum[ACCW-1:0];
                end
`else
                acc_nxt[i][j] = sum;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || tile_start) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    acc[i][j]    <= '0;
                    a_pipe[i][j] <= '0;
                    w_pipe[i][j] <= '0;
                end
                for (int d = 0; d < ROWS; d++) begin
                    a_dl[i][d] <= '0;
                end
            end
            for (int j = 0; j < COLS; j++) begin
                for (int d = 0; d < COLS; d++) begin
                    w_dl[j][d] <= '0;
                end
            end
            beat_cnt <= '0;
            out_row  <= '0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    acc[i][j]    <= acc_nxt[i][j];
                    a_pipe[i][j] <= a_in[i][j];
                    w_pipe[i][j] <= w_in[i][j];
                end
                for (int d = 0; d < ROWS; d++) begin
                    a_dl[i][d] <= (d == 0) ? beat_a[i] : a_dl[i][(d > 0) ? d - 1 : 0];
                end
            end
            for (int j = 0; j < COLS; j++) begin
                for (int d = 0; d < COLS; d++) begin
                    w_dl[j][d] <= (d == 0) ? beat_w[j] : w_dl[j][(d > 0) ? d - 1 : 0];
                end
            end
            if (accept) begin
                beat_cnt <= beat_cnt + KW'(1);
            end
            if (out_fire) begin
                out_row <= last_row ? '0 : out_row + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg <= '0;
        end else if (tile_start) begin
            k_reg <= k_len;
        end
    end

    // Down-counter preloaded outside FLUSH; terminal count ends the flush window.
    always_ff @(posedge clk) begin
        if (rst || state != FLUSH) begin
            flush_cnt <= FW'(ROWS + COLS - 2);
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FW'(1);
        end
    end

`ifdef SYSARR_SAT_EN
    always_ff @(posedge clk) begin
        if (rst || tile_start) begin
            sat_flag <= 1'b0;
        end else if (ovf_any) begin
            sat_flag <= 1'b1;
        end
    end
`else
    assign sat_flag = 1'b0;
`endif

    always_comb begin
        out_r = '0;
        if (state == DRAIN) begin
            for (int j = 0; j < COLS; j++) begin
                out_r[j*ACCW +: ACCW] = acc[out_row][j];
            end
        end
    end

endmodule

// File: tb/tb_sys_arr.sv
// Self-checking bench for sys_arr: 32-bit and 16-bit accumulator instances share stimulus and
// are checked every DRAIN cycle against a matrix-product model.
module tb_sys_arr;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int KW   = 8;
    localparam int MAXK = 8;
`ifdef SYSARR_SAT_EN
    localparam longint LIT16 = 32767;
`else
    localparam longint LIT16 = -17149;
`endif

    logic clk = 1'b0;
    logic rst, start, in_valid, out_ready;
    logic [KW-1:0] k_len;
    logic [ROWS*DW-1:0] in_a;
    logic [COLS*DW-1:0] in_w;
    logic in_ready, out_valid, busy, sat_flag;
    logic [1:0] out_row;
    logic [COLS*32-1:0] out_r;
    logic in_ready16, out_valid16, busy16, sat16;
    logic [1:0] out_row16;
    logic [COLS*16-1:0] out_r16;

    sys_arr #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACCW(32), .KMAX(255)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_r(out_r),
        .busy(busy), .sat_flag(sat_flag)
    );

    sys_arr #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACCW(16), .KMAX(255)) dut16 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_w(in_w),
        .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16), .out_r(out_r16),
        .busy(busy16), .sat_flag(sat16)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ma [ROWS][MAXK];
    int mw [MAXK][COLS];
    longint exp32 [ROWS][COLS];
    longint exp16 [ROWS][COLS];
    bit esat32, esat16;
    int exp_row, rows_seen, lit_mode;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint wrapn(input longint v, input int n);
        longint span = longint'(1) << n;
        longint r = v & (span - 1);
        if (r >= span / 2) r = r - span;
        return r;
    endfunction

    task automatic build_model(input int k);
        longint a32, a16, p, hi32, lo32, hi16, lo16;
        hi32 = (longint'(1) << 31) - 1; lo32 = -(longint'(1) << 31);
        hi16 = (longint'(1) << 15) - 1; lo16 = -(longint'(1) << 15);
        esat32 = 0; esat16 = 0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                a32 = 0; a16 = 0;
                for (int kk = 0; kk < k; kk++) begin
                    p = longint'(ma[i][kk]) * longint'(mw[kk][j]);
`ifdef SYSARR_SAT_EN
                    a32 = a32 + p;
                    if (a32 > hi32) begin a32 = hi32; esat32 = 1; end
                    if (a32 < lo32) begin a32 = lo32; esat32 = 1; end
                    a16 = a16 + p;
                    if (a16 > hi16) begin a16 = hi16; esat16 = 1; end
                    if (a16 < lo16) begin a16 = lo16; esat16 = 1; end
`else
                    a32 = wrapn(a32 + p, 32);
                    a16 = wrapn(a16 + p, 16);
`endif
                end
                exp32[i][j] = a32;
                exp16[i][j] = a16;
            end
        end
    endtask

    // Result monitor: every presented row must match the model; exp_row only advances on handshake.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_row >= ROWS) begin
                chk("extra_row", exp_row, ROWS - 1);
            end else begin
                chk("out_row", out_row, exp_row);
                chk("out_row16", out_row16, exp_row);
                chk("out_valid16", out_valid16, 1);
                for (int j = 0; j < COLS; j++) begin
                    chk("out_r32", $signed(out_r[j*32 +: 32]), exp32[exp_row][j]);
                    chk("out_r16", $signed(out_r16[j*16 +: 16]), exp16[exp_row][j]);
                    case (lit_mode)
                        1: chk("lit_identity", $signed(out_r[j*32 +: 32]), exp_row * 4 + j);
                        2: chk("lit_49152", $signed(out_r[j*32 +: 32]), 49152);
                        3: begin
                            chk("lit_48387", $signed(out_r[j*32 +: 32]), 48387);
                            chk("lit_acc16", $signed(out_r16[j*16 +: 16]), LIT16);
                        end
                        4: chk("lit_zero", $signed(out_r[j*32 +: 32]), 0);
                        default: ;
                    endcase
                end
                if (out_ready) begin
                    exp_row++;
                    rows_seen++;
                end
            end
        end
    end

    task automatic pulse_start(input int k);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_beat(input int b);
        for (int i = 0; i < ROWS; i++) in_a[i*DW +: DW] = 8'(ma[i][b]);
        for (int j = 0; j < COLS; j++) in_w[j*DW +: DW] = 8'(mw[b][j]);
    endtask

    task automatic run_tile(input int k, input bit toggle, input int stall_row, input int stall_n,
                            input bit noise, input int lit, input int lat_exp);
        int beat, cyc, first_acc, stall_left;
        bit seen_valid;
        build_model(k);
        lit_mode = lit; exp_row = 0; rows_seen = 0;
        pulse_start(k);
        chk("sat_cleared_by_start", sat16, 0);
        chk("busy_after_start", busy, 1);
        beat = 0; cyc = 0; first_acc = -1; seen_valid = 0; stall_left = stall_n;
        while (rows_seen < ROWS && cyc < 3000) begin
            if (beat < k) begin
                in_valid = !toggle || (cyc % 2 == 0);
                drive_beat(beat);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid && !seen_valid) begin
                seen_valid = 1;
                if (lat_exp > 0) chk("first_valid_latency", cyc - first_acc + 1, lat_exp);
            end
            if (k == 0) chk("k0_no_in_ready", in_ready | in_ready16, 0);
            if (k == 0 && cyc == 0) chk("k0_immediate_drain", out_valid, 1);
            if (out_valid && exp_row == stall_row && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            start = noise && ((cyc == 2) || (out_valid && out_ready && exp_row == ROWS - 1));
            k_len = noise ? 8'd5 : KW'(k);
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("tile_rows", rows_seen, ROWS);
        chk("stall_consumed", stall_left, 0);
        chk("idle_after_tile", busy | busy16, 0);
        chk("sat32", sat_flag, esat32);
        chk("sat16", sat16, esat16);
        lit_mode = 0;
    endtask

    task automatic fill_const(input int av, input int wv);
        for (int i = 0; i < ROWS; i++) for (int kk = 0; kk < MAXK; kk++) ma[i][kk] = av;
        for (int kk = 0; kk < MAXK; kk++) for (int j = 0; j < COLS; j++) mw[kk][j] = wv;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < ROWS; i++) for (int kk = 0; kk < MAXK; kk++)
            ma[i][kk] = int'($urandom_range(0, 255)) - 128;
        for (int kk = 0; kk < MAXK; kk++) for (int j = 0; j < COLS; j++)
            mw[kk][j] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        int beat, guard;
        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_w = '0; exp_row = 0; rows_seen = 0; lit_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_sat", sat_flag | sat16, 0);
        rst = 1'b0;

        // Identity A against W[k][j] = 4k+j: rows reproduce W.
        for (int i = 0; i < ROWS; i++) for (int kk = 0; kk < MAXK; kk++) ma[i][kk] = (i == kk) ? 1 : 0;
        for (int kk = 0; kk < MAXK; kk++) for (int j = 0; j < COLS; j++) mw[kk][j] = kk * 4 + j;
        run_tile(4, 0, -1, 0, 0, 1, 12);

        fill_const(-128, -128);
        run_tile(3, 0, -1, 0, 0, 2, 0);
        run_tile(3, 1, -1, 0, 0, 2, 0);

        run_tile(0, 0, -1, 0, 0, 4, 0);

        fill_rand();
        run_tile(6, 0, 2, 5, 1, 0, 0);

        fill_const(127, 127);
        run_tile(3, 0, -1, 0, 0, 3, 0);

        // Abandon a tile in FLUSH with reset; nothing may be emitted.
        fill_rand();
        build_model(4);
        exp_row = 0; rows_seen = 0;
        pulse_start(4);
        beat = 0; guard = 0;
        while (beat < 4 && guard < 100) begin
            in_valid = 1'b1;
            drive_beat(beat);
            if (in_ready) beat++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("beats_before_rst", beat, 4);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_in_flush", busy, 1);
        chk("no_valid_in_flush", out_valid, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_flush_busy", busy | busy16, 0);
        chk("rst_flush_out_valid", out_valid, 0);
        chk("rst_flush_in_ready", in_ready, 0);
        chk("rst_flush_out_r", out_r, 0);
        repeat (15) @(posedge clk);
        #1;
        chk("no_partial_result", rows_seen, 0);

        fill_rand();
        run_tile(5, 1, -1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
